ervp_lpixm_axi_mo_bridge: RTL
=============================

# ervp_lpixm_axi_mo_bridge

Multi-outstanding bridge from an LPI memory-ordered request/response port to a single-beat AXI4 master. It sits between an LPI memory client and the AXI interconnect, the same role as the existing single-outstanding LPI-to-AXI bridge. It adds a configurable number of in-flight transactions, independent AW/W handshaking and strictly in-order responses across mixed reads and writes.

## Interface
- BW_ADDR, 32, address width (LPI and AXI)
- BW_DATA, 32, data width, power of two, ≥ 8
- BW_AXI_TID, 1, AXI ID width
- AXI_ID, 0, constant ID driven on AWID/ARID
- MAX_OUTSTANDING, 4, order-FIFO depth, power of two, 2..64
- clk  in  1  clock
- rstnn  in  1  reset, asynchronous, active-low
- sreq_valid  in  1  LPI request valid
- sreq_ready  out  1  LPI request ready
- sreq_write  in  1  1 = write, 0 = read
- sreq_addr  in  BW_ADDR  byte address
- sreq_wdata  in  BW_DATA  write data
- sreq_wstrb  in  BW_DATA/8  byte enables (writes only)
- sresp_valid  out  1  LPI response valid
- sresp_ready  in  1  LPI response ready
- sresp_rdata  out  BW_DATA  read data; 0 for write responses
- sresp_error  out  1  1 when RRESP/BRESP ≠ OKAY
- idle  out  1  no request held and order FIFO empty
- AXI AW: awid[BW_AXI_TID], awaddr[BW_ADDR], awlen[8], awsize[3], awburst[2], awvalid out, awready in
- AXI W: wdata[BW_DATA], wstrb[BW_DATA/8], wlast, wvalid out, wready in
- AXI B: bid[BW_AXI_TID], bresp[2], bvalid in, bready out
- AXI AR: arid, araddr, arlen, arsize, arburst, arvalid out, arready in
- AXI R: rid, rdata[BW_DATA], rresp[2], rlast, rvalid in, rready out

## Operation
- Issue register: one entry holding the request. Accept when sreq_valid & sreq_ready. sreq_ready = !issue_full & (count < MAX_OUTSTANDING).
- On accept: load the issue register and push sreq_write into the order FIFO in the same cycle. count increments.
- Write issue: awvalid and wvalid are both asserted from the cycle after accept. Flags aw_done and w_done are set on the respective handshake. Each valid drops after its own handshake. The entry retires in the cycle in which both handshakes have completed; the two handshakes may occur in the same cycle or in either order.
- Read issue: arvalid is asserted from the cycle after accept and the entry retires on arready.
- Retire and a new accept in the same cycle are not allowed, because sreq_ready depends only on registered state. Peak throughput is therefore one request every 2 cycles.
- Constant fields: awlen/arlen = 0, awsize/arsize = log2(BW_DATA/8), awburst/arburst = 2'b01, wlast = 1, awid/arid = AXI_ID.
- Response path: the head of the order FIFO selects the source. Head = read: sresp_valid = rvalid, rready = sresp_ready, bready = 0. Head = write: sresp_valid = bvalid, bready = sresp_ready, rready = 0. FIFO empty: sresp_valid, rready and bready are all 0.
- Pop and count decrement happen on sresp_valid & sresp_ready. A push and a pop in the same cycle leave count unchanged.
- sresp_error = selected resp[1]. rid, bid and rlast are ignored, because a single ID gives in-order AXI returns.
- Reads are never issued ahead of an older write, and vice versa: issue order equals accept order.

## Timing
- Reset values: sreq_ready 0 during reset and 1 in the first cycle after deassertion. All AXI valids 0; bready, rready and sresp_valid 0; idle 1; count 0; flags 0.
- Request to AXI valid: 1 cycle after accept, registered.
- AXI response to LPI response: 0 cycles, combinational pass-through. The LPI side must tolerate this.
- Full (count = MAX_OUTSTANDING): sreq_ready = 0 even if a pop occurs in the same cycle. sreq_ready rises the cycle after the pop.
- Count wraps are impossible by construction. The FIFO pointers are log2(MAX_OUTSTANDING)+1 bits with wrap-bit full detection.
- Reset mid-operation: all state clears immediately. In-flight AXI transactions are lost, and system-level reset of the interconnect is required.
- idle = !issue_full & (count == 0), registered-state only.

## Configuration
- LPIXM_AXI_ERROR_STICKY_EN defined: adds input err_clear (1 bit) and output err_sticky (1 bit, reset 0).
  - err_sticky is set on any popped response with resp[1] = 1.
  - err_clear clears it on the next edge. Set wins over a simultaneous clear.
- Undefined: those ports and that logic are absent. sresp_error is unaffected in both cases.

## Test plan
- Single read, addr 0x100, arready after 2 cycles, rdata 0xDEADBEEF with OKAY -> arvalid rises 1 cycle after accept; sresp_rdata = 0xDEADBEEF, sresp_error = 0; idle returns to 1.
- Write 0x200 / 0x12345678 / strb 0xF with wready 3 cycles before awready -> wvalid drops after its own handshake; retire only after AW; one response with rdata 0.
- MAX_OUTSTANDING = 4, 4 reads accepted with rvalid withheld -> 5th request sees sreq_ready = 0; after one R pop, sreq_ready = 1 the next cycle.
- Mixed sequence W, R, W with B and R returns stalled by sresp_ready toggling -> responses delivered in W, R, W order; bready/rready never asserted for the non-head channel.
- R with rresp = 2'b10 -> sresp_error = 1; with the macro defined, err_sticky = 1 until err_clear; err_clear coinciding with a new error leaves it 1.
- rstnn asserted while 2 reads are outstanding -> all valids 0, count 0 and idle 1 immediately; sreq_ready = 1 after release.

Source files
------------

// File: rtl/ervp_lpixm_axi_mo_bridge.sv
`timescale 1ns/1ps
// ervp_lpixm_axi_mo_bridge
// Multi-outstanding LPI request/response to single-beat AXI4 master bridge.
// One issue register feeds AW/W or AR. An order FIFO remembers read/write
// per accepted request, so responses come back to LPI strictly in accept order.
// Optional feature macro: LPIXM_AXI_ERROR_STICKY_EN adds err_clear/err_sticky.
module ervp_lpixm_axi_mo_bridge #(
    parameter int BW_ADDR         = 32,
    parameter int BW_DATA         = 32,
    parameter int BW_AXI_TID      = 1,
    parameter int AXI_ID          = 0,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                    clk,
    input  logic                    rstnn,
    input  logic                    sreq_valid,
    output logic                    sreq_ready,
    input  logic                    sreq_write,
    input  logic [BW_ADDR-1:0]      sreq_addr,
    input  logic [BW_DATA-1:0]      sreq_wdata,
    input  logic [BW_DATA/8-1:0]    sreq_wstrb,
    output logic                    sresp_valid,
    input  logic                    sresp_ready,
    output logic [BW_DATA-1:0]      sresp_rdata,
    output logic                    sresp_error,
`ifdef LPIXM_AXI_ERROR_STICKY_EN
    input  logic                    err_clear,
    output logic                    err_sticky,
`endif
    output logic                    idle,
    output logic [BW_AXI_TID-1:0]   awid,
    output logic [BW_ADDR-1:0]      awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [BW_DATA-1:0]      wdata,
    output logic [BW_DATA/8-1:0]    wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [BW_AXI_TID-1:0]   bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready,
    output logic [BW_AXI_TID-1:0]   arid,
    output logic [BW_ADDR-1:0]      araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [BW_AXI_TID-1:0]   rid,
    input  logic [BW_DATA-1:0]      rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready
);

    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int BW_STRB = BW_DATA / 8;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(BW_STRB));

    logic                 issue_full;
    logic                 issue_write;
    logic [BW_ADDR-1:0]   issue_addr;
    logic [BW_DATA-1:0]   issue_wdata;
    logic [BW_STRB-1:0]   issue_wstrb;
    logic                 aw_done;
    logic                 w_done;

    logic [MAX_OUTSTANDING-1:0] order_q;
    logic [PW:0]                wptr;
    logic [PW:0]                rptr;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic                       head_write;

    logic accept, retire, pop;
    logic aw_hs, w_hs, ar_hs;

    // rid/bid/rlast carry no information with a single in-order ID
    logic unused_inputs;
    assign unused_inputs = ^{rid, bid, rlast};

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign head_write = order_q[rptr[PW-1:0]];

    // Gated by rstnn so the request side is closed while reset is held
    assign sreq_ready = rstnn & ~issue_full & ~fifo_full;
    assign accept     = sreq_valid & sreq_ready;
    assign idle       = ~issue_full & fifo_empty;

    assign awvalid = issue_full & issue_write & ~aw_done;
    assign wvalid  = issue_full & issue_write & ~w_done;
    assign arvalid = issue_full & ~issue_write;
    assign aw_hs   = awvalid & awready;
    assign w_hs    = wvalid & wready;
    assign ar_hs   = arvalid & arready;
    assign retire  = issue_full & (issue_write ? ((aw_done | aw_hs) & (w_done | w_hs)) : ar_hs);

    assign awid    = BW_AXI_TID'(AXI_ID);
    assign awaddr  = issue_addr;
    assign awlen   = '0;
    assign awsize  = AXI_SIZE;
    assign awburst = 2'b01;
    assign wdata   = issue_wdata;
    assign wstrb   = issue_wstrb;
    assign wlast   = 1'b1;
    assign arid    = BW_AXI_TID'(AXI_ID);
    assign araddr  = issue_addr;
    assign arlen   = '0;
    assign arsize  = AXI_SIZE;
    assign arburst = 2'b01;

    // Issue register: load on accept, track AW/W completion, free on retire
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            issue_full  <= 1'b0;
            issue_write <= 1'b0;
            issue_addr  <= '0;
            issue_wdata <= '0;
            issue_wstrb <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else if (accept) begin
            issue_full  <= 1'b1;
            issue_write <= sreq_write;
            issue_addr  <= sreq_addr;
            issue_wdata <= sreq_wdata;
            issue_wstrb <= sreq_wstrb;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else if (retire) begin
            issue_full  <= 1'b0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
        end else begin
            if (aw_hs) aw_done <= 1'b1;
            if (w_hs)  w_done  <= 1'b1;
        end
    end

    // Order FIFO: push request type on accept, pop on LPI response handshake
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            order_q <= '0;
            wptr    <= '0;
            rptr    <= '0;
        end else begin
            if (accept) begin
                order_q[wptr[PW-1:0]] <= sreq_write;
                wptr <= wptr + (PW+1)'(1);
            end
            if (pop) rptr <= rptr + (PW+1)'(1);
        end
    end

    // Response steering: FIFO head picks the B or R channel, the other stays stalled
    always_comb begin
        sresp_valid = 1'b0;
        sresp_rdata = '0;
        sresp_error = 1'b0;
        bready      = 1'b0;
        rready      = 1'b0;
        if (!fifo_empty) begin
            if (head_write) begin
                sresp_valid = bvalid;
                sresp_error = bresp[1];
                bready      = sresp_ready;
            end else begin
                sresp_valid = rvalid;
                sresp_rdata = rdata;
                sresp_error = rresp[1];
                rready      = sresp_ready;
            end
        end
    end

    assign pop = sresp_valid & sresp_ready;

`ifdef LPIXM_AXI_ERROR_STICKY_EN
    // Sticky error: set by any popped error response, set beats a same-cycle clear
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            err_sticky <= 1'b0;
        end else if (pop && sresp_error) begin
            err_sticky <= 1'b1;
        end else if (err_clear) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule
